// File: rtl/srambank_pkg.sv
// Shared types and width helpers for the banked SRAM controller.
package srambank_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  localparam int DEF_WORD_W         = 16;
  localparam int DEF_BYTE_W         = 8;
  localparam int DEF_WORDS_PER_BANK = 256;
  localparam int DEF_NUM_BANKS      = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // A single bank still carries a one-bit select so vectors never collapse to zero width.
  function automatic int bank_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/srambank_bank.sv
// One non-resettable synchronous SRAM bank with byte-masked writes and a
// read register that only moves on a read.
module srambank_bank
  import srambank_pkg::*;
#(
  parameter  int WORD_W = DEF_WORD_W,
  parameter  int BYTE_W = DEF_BYTE_W,
  parameter  int WORDS  = DEF_WORDS_PER_BANK,
  localparam int IDX_W  = clog2(WORDS),
  localparam int MASK_W = WORD_W / BYTE_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [MASK_W-1:0] wmask,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (wmask[i]) mem[idx][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
    if (en && !we) rdata_q <= mem[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/srambank_array_ctl.sv
// Banked SRAM controller: one valid/ready port, upper address bits pick the bank,
// zero-fill sequencer after reset or clear, read latency 1 or 2.
module srambank_array_ctl
  import srambank_pkg::*;
#(
  parameter  int WORD_W         = DEF_WORD_W,
  parameter  int BYTE_W         = DEF_BYTE_W,
  parameter  int WORDS_PER_BANK = DEF_WORDS_PER_BANK,
  parameter  int NUM_BANKS      = DEF_NUM_BANKS,
  parameter  int OUT_REG        = 0,
  localparam int IDX_W          = clog2(WORDS_PER_BANK),
  localparam int BANK_W         = bank_w(NUM_BANKS),
  localparam int ADDR_W         = clog2(NUM_BANKS * WORDS_PER_BANK),
  localparam int MASK_W         = WORD_W / BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rd_valid,
  output logic [WORD_W-1:0] rd_data,
  output logic              init_done
);

  localparam int STAGES = (OUT_REG != 0) ? 2 : 1;

  state_e                           state_q, state_d;
  logic [IDX_W-1:0]                 cnt_q, cnt_d;
  logic [BANK_W-1:0]                sel_q, sel_d;
  logic [STAGES-1:0]                vld_pipe_q, vld_pipe_d;
  logic                             accept, rd_issue;
  logic [BANK_W-1:0]                req_bank;
  logic [NUM_BANKS-1:0]             bank_en;
  logic                             bank_we;
  logic [MASK_W-1:0]                bank_mask;
  logic [IDX_W-1:0]                 bank_idx;
  logic [WORD_W-1:0]                bank_wdata;
  logic [NUM_BANKS-1:0][WORD_W-1:0] bank_rdata;
  logic [WORD_W-1:0]                mux_rdata;

  if (NUM_BANKS > 1) begin : g_dec
    assign req_bank = req_addr[ADDR_W-1 -: BANK_W];
  end else begin : g_nodec
    assign req_bank = '0;
  end

  assign req_ready = (state_q == RUN);
  assign init_done = (state_q == RUN);
  assign accept    = req_valid & req_ready;
  assign rd_issue  = accept & ~req_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == IDX_W'(WORDS_PER_BANK - 1)) state_d = RUN;
    end else if (clear) begin
      state_d = INIT;
      cnt_d   = '0;
    end
  end

  // INIT drives every bank with a full-mask zero write; RUN enables only the addressed bank.
  always_comb begin
    bank_en    = '1;
    bank_we    = 1'b1;
    bank_mask  = '1;
    bank_idx   = cnt_q;
    bank_wdata = '0;
    if (state_q == RUN) begin
      bank_we    = req_write;
      bank_mask  = req_wmask;
      bank_idx   = req_addr[IDX_W-1:0];
      bank_wdata = req_wdata;
      for (int b = 0; b < NUM_BANKS; b++) bank_en[b] = accept && (req_bank == BANK_W'(b));
    end
  end

  always_comb begin
    sel_d      = rd_issue ? req_bank : sel_q;
    vld_pipe_d = STAGES'({vld_pipe_q, rd_issue});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      sel_q      <= '0;
      vld_pipe_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    srambank_bank #(
      .WORD_W(WORD_W),
      .BYTE_W(BYTE_W),
      .WORDS (WORDS_PER_BANK)
    ) u_bank (
      .clk  (clk),
      .en   (bank_en[b]),
      .we   (bank_we),
      .wmask(bank_mask),
      .idx  (bank_idx),
      .wdata(bank_wdata),
      .rdata(bank_rdata[b])
    );
  end

  assign mux_rdata = bank_rdata[sel_q];
  assign rd_valid  = vld_pipe_q[STAGES-1];

  if (OUT_REG != 0) begin : g_oreg
    logic [WORD_W-1:0] out_q, out_d;
    always_comb out_d = vld_pipe_q[0] ? mux_rdata : out_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_q <= '0;
      else        out_q <= out_d;
    end
    assign rd_data = out_q;
  end else begin : g_noreg
    // Bank read registers have no reset, so mask them until the first read lands.
    logic has_q, has_d;
    always_comb has_d = has_q | rd_issue;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) has_q <= 1'b0;
      else        has_q <= has_d;
    end
    assign rd_data = has_q ? mux_rdata : '0;
  end

endmodule
